// File: rtl/rs_rr_burst_arbiter.sv
// Round-robin burst arbiter: NUM_SRC valid/ready sources onto one
// registered downstream channel. Whole bursts are granted, up to the beat with last=1.
module rs_rr_burst_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int PW = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH,
    localparam int SW = $clog2(NUM_SRC)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC-1:0]    src_last_i,
    input  logic [NUM_SRC*PW-1:0] src_data_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    output logic                  dst_valid_o,
    output logic                  dst_last_o,
    output logic [PW-1:0]         dst_data_o,
    output logic [SW-1:0]         dst_src_o,
    input  logic                  dst_ready_i
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     lock_q, lock_d;
    logic              load;
    logic [SW-1:0]     win;
    logic              win_ok;
    int                idx;
    logic [NUM_SRC-1:0] ready;
    logic              acc;
    logic [SW-1:0]     sel;

    // The output register can take a new beat when empty or being drained.
    assign load = !dst_valid_o || dst_ready_i;

    // Pick the first valid source after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_SRC;
            if (!win_ok && src_valid_i[idx]) begin
                win    = SW'(idx);
                win_ok = 1'b1;
            end
        end
    end

    // Grant, accept and next-state: arbitrate in IDLE, hold the lock in BURST.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        ready    = '0;
        acc      = 1'b0;
        sel      = win;
        unique case (state_q)
            IDLE: begin
                if (load && win_ok) begin
                    ready[win] = 1'b1;
                    acc        = 1'b1;
                    if (src_last_i[win]) begin
                        rr_ptr_d = win;
                    end else begin
                        lock_d  = win;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                sel           = lock_q;
                ready[lock_q] = load;
                if (load && src_valid_i[lock_q]) begin
                    acc = 1'b1;
                    if (src_last_i[lock_q]) begin
                        rr_ptr_d = lock_q;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // No source may see ready while reset is held.
    assign src_ready_o = areset ? '0 : ready;

    // Arbiter state and the registered output beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SW'(NUM_SRC - 1);
            lock_q      <= '0;
            dst_valid_o <= 1'b0;
            dst_last_o  <= 1'b0;
            dst_data_o  <= '0;
            dst_src_o   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            if (load) begin
                dst_valid_o <= acc;
                if (acc) begin
                    dst_data_o <= src_data_i[int'(sel)*PW +: PW];
                    dst_last_o <= src_last_i[sel];
                    dst_src_o  <= sel;
                end
            end
        end
    end

endmodule
